// File: rtl/pipeline_run_controller.sv
// -----------------------------------------------------------------------------
// pipeline_run_controller
//
// Run/step/pause/halt sequencer for the 5-stage MIPS pipeline. Drives the
// global pipeline stall and a fetch-only hold, watches the fetched instruction
// for HALT_WORD and lets the in-flight instructions drain before halting.
//
// Parameters:
//   SIZE          instruction width
//   HALT_WORD     instruction encoding that stops the program
//   DRAIN_CYCLES  unstalled cycles after the halt fetch (ID, EX, MEM, WB)
//   CNT_WIDTH     width of o_cycle_count
//
// Build option:
//   CYCLE_CNT_EN  when defined, o_cycle_count counts unstalled cycles and
//                 saturates at all-ones; otherwise it is tied to zero and no
//                 counter register exists.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   i_cmd_valid    in   command present
//   i_cmd          in   2'b00 nop, 2'b01 run, 2'b10 step, 2'b11 pause
//   o_cmd_ready    out  command accepted when i_cmd_valid & o_cmd_ready
//   i_instruction  in   instruction currently output by IF
//   o_stall        out  stall all pipeline latches and PC
//   o_fetch_hold   out  stall PC/IF only
//   o_halted       out  HALTED state reached
//   o_step_done    out  one-cycle pulse after a completed step
//   o_state        out  IDLE=0 RUN=1 STEP=2 DRAIN=3 HALTED=4
//   o_cycle_count  out  number of cycles with o_stall=0
// -----------------------------------------------------------------------------
module pipeline_run_controller #(
  parameter int unsigned     SIZE         = 32,
  parameter logic [SIZE-1:0] HALT_WORD    = 32'hFFFFFFFF,
  parameter int unsigned     DRAIN_CYCLES = 4,
  parameter int unsigned     CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic [SIZE-1:0]      i_instruction,
  output logic                 o_stall,
  output logic                 o_fetch_hold,
  output logic                 o_halted,
  output logic                 o_step_done,
  output logic [2:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_cycle_count
);

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    STEP   = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  state_t        halt_target;
  logic [DW-1:0] drain_cnt;
  logic          step_done;
  logic          halt_fetch;
  logic          cmd_accept;

  assign halt_fetch  = (i_instruction == HALT_WORD);
  assign cmd_accept  = i_cmd_valid & o_cmd_ready;
  // With no drain window the halt fetch goes straight to HALTED.
  assign halt_target = (DRAIN_CYCLES == 0) ? HALTED : DRAIN;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (cmd_accept) begin
          if (i_cmd == CMD_RUN) begin
            next_state = RUN;
          end else if (i_cmd == CMD_STEP) begin
            next_state = STEP;
          end
        end
      end
      RUN: begin
        // A halt fetch outranks any command offered in the same cycle.
        if (halt_fetch) begin
          next_state = halt_target;
        end else if (cmd_accept && (i_cmd == CMD_PAUSE)) begin
          next_state = IDLE;
        end
      end
      STEP: begin
        next_state = halt_fetch ? halt_target : IDLE;
      end
      DRAIN: begin
        if (drain_cnt <= DW'(1)) begin
          next_state = HALTED;
        end
      end
      HALTED: begin
        next_state = HALTED;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output decode (Moore)
  always_comb begin
    o_stall      = 1'b1;
    o_fetch_hold = 1'b1;
    o_cmd_ready  = 1'b0;
    o_halted     = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
      end
      RUN: begin
        o_stall      = 1'b0;
        o_fetch_hold = 1'b0;
        o_cmd_ready  = 1'b1;
      end
      STEP: begin
        o_stall      = 1'b0;
        o_fetch_hold = 1'b0;
      end
      DRAIN: begin
        o_stall = 1'b0;
      end
      HALTED: begin
        o_halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign o_state     = state;
  assign o_step_done = step_done;

  // Drain counter: loaded on entry to DRAIN, counts down while draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if ((state != DRAIN) && (next_state == DRAIN)) begin
      drain_cnt <= DW'(DRAIN_CYCLES);
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt - DW'(1);
    end
  end

  // Registered alongside the STEP->IDLE transition so the pulse coincides
  // with the first IDLE cycle; a halt during STEP suppresses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_done <= 1'b0;
    end else begin
      step_done <= (state == STEP) && (next_state == IDLE);
    end
  end

`ifdef CYCLE_CNT_EN
  logic [CNT_WIDTH-1:0] cycle_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (!o_stall && (cycle_count != '1)) begin
      cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
  end

  assign o_cycle_count = cycle_count;
`else
  assign o_cycle_count = '0;
`endif

endmodule
